// File: rtl/nn_pkg.sv
// Shared definitions for the neuron-array output stage.
//   state_t     : argmax FSM state encodings (ST_COLLECT, ST_DONE)
//   idx_width() : class-index width for a given number of classes
//   res_min()   : most-negative two's complement value of a given width,
//                 returned in the low bits of a 64-bit word (RES_MIN source)
package nn_pkg;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_DONE    = 1'b1
  } state_t;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [63:0] res_min(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/argmax_classifier_score_compare.sv
// score_compare: signed strict greater-than of two resolution-bit values.
//   i_a, i_b : two's complement operands
//   o_gt     : 1 when i_a > i_b (signed); 0 on equality
module score_compare #(
  parameter int resolution = 8
) (
  input  logic [resolution-1:0] i_a,
  input  logic [resolution-1:0] i_b,
  output logic                  o_gt
);

  assign o_gt = $signed(i_a) > $signed(i_b);

endmodule

// File: rtl/argmax_classifier.sv
// argmax_classifier: takes num_classes signed scores per frame, one per
// handshake, and reports the index and value of the largest one.
// Optional feature macro: ARGMAX_MARGIN_EN (adds second-best tracking and
// the margin output).
//   clk, reset   : clock, asynchronous active-high reset
//   clear        : synchronous frame abort
//   score_in     : signed score; score_valid / score_ready handshake
//   result_ack   : consumer takes the result
//   result_valid : digit / max_score (/ margin) valid
//   digit        : index of the maximum score (ties keep the lower index)
//   max_score    : signed maximum score
//   margin       : unsigned max minus second-best (ARGMAX_MARGIN_EN only)
module argmax_classifier
  import nn_pkg::*;
#(
  parameter int num_classes = 10,
  parameter int resolution  = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               clear,
  input  logic [resolution-1:0]              score_in,
  input  logic                               score_valid,
  output logic                               score_ready,
  input  logic                               result_ack,
  output logic                               result_valid,
  output logic [idx_width(num_classes)-1:0]  digit,
  output logic [resolution-1:0]              max_score
`ifdef ARGMAX_MARGIN_EN
  ,
  output logic [resolution:0]                margin
`endif
);

  localparam int IW = idx_width(num_classes);
  localparam logic [IW-1:0] LAST_IDX = IW'(num_classes - 1);

  state_t                r_state;
  logic [IW-1:0]         r_idx;
  logic [IW-1:0]         r_digit;
  logic [resolution-1:0] r_max;

  logic                  w_accept;
  logic                  w_gt_max;
  logic [resolution-1:0] w_next_max;
  logic [IW-1:0]         w_next_digit;

  assign score_ready  = (r_state == ST_COLLECT) && !clear;
  assign result_valid = (r_state == ST_DONE);
  assign w_accept     = score_valid && score_ready;
  assign digit        = r_digit;
  assign max_score    = r_max;

  score_compare #(.resolution(resolution)) u_cmp_max (
    .i_a  (score_in),
    .i_b  (r_max),
    .o_gt (w_gt_max)
  );

`ifdef ARGMAX_MARGIN_EN
  localparam logic [63:0]           RES_MIN_W = res_min(resolution);
  localparam logic [resolution-1:0] RES_MIN   = RES_MIN_W[resolution-1:0];

  logic [resolution-1:0] r_second;
  logic [resolution:0]   r_margin;
  logic [resolution-1:0] w_next_second;
  logic                  w_gt_second;

  assign margin = r_margin;

  score_compare #(.resolution(resolution)) u_cmp_second (
    .i_a  (score_in),
    .i_b  (r_second),
    .o_gt (w_gt_second)
  );
`endif

  // Next running max/index (and second-best) if the current score is taken.
  always_comb begin
    w_next_max   = r_max;
    w_next_digit = r_digit;
`ifdef ARGMAX_MARGIN_EN
    w_next_second = r_second;
`endif
    if (r_idx == '0) begin
      w_next_max   = score_in;
      w_next_digit = '0;
`ifdef ARGMAX_MARGIN_EN
      w_next_second = RES_MIN;
`endif
    end else if (w_gt_max) begin
      w_next_max   = score_in;
      w_next_digit = r_idx;
`ifdef ARGMAX_MARGIN_EN
      w_next_second = r_max;
    end else if (w_gt_second) begin
      w_next_second = score_in;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_COLLECT;
      r_idx   <= '0;
      r_digit <= '0;
      r_max   <= '0;
`ifdef ARGMAX_MARGIN_EN
      r_second <= '0;
      r_margin <= '0;
`endif
    end else begin
      case (r_state)
        ST_COLLECT: begin
          if (clear) begin
            r_idx <= '0;
          end else if (w_accept) begin
            r_max   <= w_next_max;
            r_digit <= w_next_digit;
`ifdef ARGMAX_MARGIN_EN
            r_second <= w_next_second;
`endif
            if (r_idx == LAST_IDX) begin
              r_idx   <= '0;
              r_state <= ST_DONE;
`ifdef ARGMAX_MARGIN_EN
              // Sign-extend both operands so the difference cannot overflow.
              r_margin <= {w_next_max[resolution-1], w_next_max}
                        - {w_next_second[resolution-1], w_next_second};
`endif
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (clear || result_ack) r_state <= ST_COLLECT;
        end
        default: r_state <= ST_COLLECT;
      endcase
    end
  end

endmodule
